// File: rtl/gb_obj_pkg.sv
// Shared OAM layout constants, object heights, slot record and scanner state encoding.
package gb_obj_pkg;

   localparam logic [1:0] OAM_Y    = 2'd0;
   localparam logic [1:0] OAM_X    = 2'd1;
   localparam logic [1:0] OAM_TILE = 2'd2;
   localparam logic [1:0] OAM_ATTR = 2'd3;

   localparam int unsigned OBJ_H8  = 8;
   localparam int unsigned OBJ_H16 = 16;

   // One latched on-line object; the OAM number is kept 8 bits wide and truncated on output.
   typedef struct packed {
      logic       valid;
      logic [7:0] x;
      logic [7:0] no;
      logic [3:0] row;
   } slot_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RD_Y,
      ST_RD_X,
      ST_DONE
   } eval_state_e;

endpackage

// File: rtl/sprite_line_eval_if.sv
// OAM read bus plus the pixel-fetcher handshake of the sprite line scanner.
interface sprite_line_eval_if #(
   parameter int unsigned NUM_OBJ = 40,
   parameter int unsigned AW      = 8
);
   localparam int unsigned NW = $clog2(NUM_OBJ);

   logic [AW-1:0] oam_addr;
   logic [7:0]    oam_q;
   logic [7:0]    h_cnt;
   logic          oam_fetch;
   logic          fetch_req;
   logic [3:0]    slot_index;
   logic [NW-1:0] obj_no;
   logic [3:0]    obj_row;
   logic          fetch_done;

   modport master (
      output oam_addr, fetch_req, slot_index, obj_no, obj_row,
      input  oam_q, h_cnt, oam_fetch, fetch_done
   );

   modport slave (
      input  oam_addr, fetch_req, slot_index, obj_no, obj_row,
      output oam_q, h_cnt, oam_fetch, fetch_done
   );
endinterface

// File: rtl/obj_prio_enc.sv
// Slot match priority encoder: lowest set index wins, SLOTS-1 when nothing matches.
module obj_prio_enc #(
   parameter int unsigned SLOTS = 10
) (
   input  logic [SLOTS-1:0] match_i,
   output logic             any_c,
   output logic [3:0]       idx_c
);

   // Scan from the top down so the lowest matching index is the last one written.
   always_comb begin
      any_c = |match_i;
      idx_c = 4'(SLOTS - 1);
      for (int k = int'(SLOTS) - 1; k >= 0; k--) begin
         if (match_i[k]) idx_c = 4'(k);
      end
   end

endmodule

// File: rtl/sprite_line_eval.sv
// Per-line OAM scanner: collects up to SLOTS on-line objects in mode 2, serves X matches in mode 3.
module sprite_line_eval
   import gb_obj_pkg::*;
#(
   parameter int unsigned NUM_OBJ = 40,
   parameter int unsigned SLOTS   = 10,
   parameter int unsigned AW      = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         ce,
   input  logic                         lcd_on,
   input  logic                         size16,
   input  logic                         sprite_en,
   input  logic                         isGBC,
   input  logic [7:0]                   v_cnt,
   input  logic                         eval_start,
   sprite_line_eval_if.master           bus,
   output logic                         eval_busy,
   output logic                         eval_done,
   output logic [$clog2(SLOTS+1)-1:0]   obj_count,
   output logic                         overflow
);

   localparam int unsigned CW = $clog2(SLOTS + 1);
   localparam int unsigned NW = $clog2(NUM_OBJ);
   localparam int unsigned SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam int unsigned OW = AW - 2;

   eval_state_e   state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [NW-1:0] obj_q, obj_d;
   logic [7:0]    y_q, y_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          fd_q;
   slot_t         slots_q [SLOTS];
   slot_t         slots_d [SLOTS];

   logic [SLOTS-1:0] match;
   logic             any;
   logic [3:0]       idx;
   logic [8:0]       v_off, y9, h9;
   logic             on_line;
   logic [3:0]       row_c;
   logic             fd_edge;

   // X comparison of every valid slot against the current fetch column.
   always_comb begin
      for (int k = 0; k < int'(SLOTS); k++) begin
         match[k] = slots_q[k].valid && (slots_q[k].x == bus.h_cnt);
      end
   end

   obj_prio_enc #(.SLOTS(SLOTS)) u_prio (
      .match_i (match),
      .any_c   (any),
      .idx_c   (idx)
   );

   assign bus.fetch_req  = any && bus.oam_fetch && (isGBC || sprite_en);
   assign bus.slot_index = idx;
   assign bus.obj_no     = NW'(slots_q[SW'(idx)].no);
   assign bus.obj_row    = slots_q[SW'(idx)].row;
   assign bus.oam_addr   = addr_q;

   assign eval_busy = busy_q;
   assign eval_done = done_q;
   assign obj_count = cnt_q;
   assign overflow  = ovf_q;

   assign fd_edge = bus.fetch_done & ~fd_q;

   // Vertical range test on 9-bit operands; row is the low nibble of (v+16-y).
   always_comb begin
      v_off   = 9'(v_cnt) + 9'd16;
      y9      = 9'(y_q);
      h9      = size16 ? 9'(OBJ_H16) : 9'(OBJ_H8);
      on_line = (v_off >= y9) && (v_off < (y9 + h9));
      row_c   = v_off[3:0] - y_q[3:0];
   end

   // Scan sequencing, slot fill, retire and line clear; clear is applied last so it wins.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      obj_d   = obj_q;
      y_d     = y_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      busy_d  = busy_q;
      done_d  = done_q;
      slots_d = slots_q;

      case (state_q)
         ST_RD_Y: begin
            y_d     = bus.oam_q;
            addr_d  = {OW'(obj_q), OAM_X};
            state_d = ST_RD_X;
         end
         ST_RD_X: begin
            if (on_line) begin
               if (cnt_q < CW'(SLOTS)) begin
                  slots_d[SW'(cnt_q)] = '{valid: 1'b1, x: bus.oam_q, no: 8'(obj_q), row: row_c};
                  cnt_d = cnt_q + CW'(1);
               end else begin
                  ovf_d = 1'b1;
               end
            end
            addr_d = {OW'(obj_q) + OW'(1), OAM_Y};
            obj_d  = obj_q + NW'(1);
            if (obj_q == NW'(NUM_OBJ - 1)) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               state_d = ST_RD_Y;
            end
         end
         default: ;
      endcase

      if (fd_edge && any) slots_d[SW'(idx)].valid = 1'b0;

      if (!lcd_on || eval_start) begin
         for (int k = 0; k < int'(SLOTS); k++) slots_d[k].valid = 1'b0;
         cnt_d  = '0;
         ovf_d  = 1'b0;
         done_d = 1'b0;
         obj_d  = '0;
         addr_d = '0;
         if (lcd_on) begin
            state_d = ST_RD_Y;
            busy_d  = 1'b1;
         end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      end
   end

   // State registers; everything but reset advances on the pixel clock enable.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         obj_q   <= '0;
         y_q     <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         fd_q    <= 1'b0;
         for (int k = 0; k < int'(SLOTS); k++) slots_q[k] <= '0;
      end else if (ce) begin
         state_q <= state_d;
         addr_q  <= addr_d;
         obj_q   <= obj_d;
         y_q     <= y_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         fd_q    <= bus.fetch_done;
         slots_q <= slots_d;
      end
   end

endmodule
